// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch unit for the MIPS core.
// Cycles: IDLE, FETCH (req held until ack), EXEC (instr held until step); 2 cycles/instr minimum.
// Optional feature: define NPC_JR_EN to make NPCOp=11 jump to JRTarget (otherwise PC+4).
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  NPCOp,
  input  logic [15:0] IMM16,
  input  logic [25:0] IMM26,
  input  logic [31:0] JRTarget,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPLUS4
);

  // Reset PC is word aligned regardless of the parameter value.
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pcplus4;
  logic [31:0] br_off;
  logic [31:0] npc_d;
  logic        unused_jr;

  assign pcplus4 = pc_q + 32'd4;
  assign br_off  = {{14{IMM16[15]}}, IMM16, 2'b00};

  // Next-PC select; every source is word aligned so PC[1:0] stays zero.
  always_comb begin
    npc_d = pcplus4;
    case (NPCOp)
      2'b01:   npc_d = pcplus4 + br_off;
      2'b10:   npc_d = {pcplus4[31:28], IMM26, 2'b00};
      2'b11: begin
`ifdef NPC_JR_EN
        npc_d = {JRTarget[31:2], 2'b00};
`else
        npc_d = pcplus4;
`endif
      end
      default: npc_d = pcplus4;
    endcase
  end

`ifdef NPC_JR_EN
  assign unused_jr = ^JRTarget[1:0];
`else
  assign unused_jr = ^JRTarget;
`endif

  // Fetch/execute sequencer with registered req/valid; reset abandons any request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_PC;
      instr_q <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (step) begin
            pc_q    <= npc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PCPLUS4     = pcplus4;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch unit for the MIPS core. Holds the PC, fetches one instruction per step over a req/ack handshake with instruction memory, and presents it to the decode/control stage. Consumes the NPCOp code produced by the control unit and computes the next PC for sequential, branch and jump flow.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; bits [1:0] forced to 0.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- NPCOp  in  2  next-PC select from control: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR (see Configuration).
- IMM16  in  16  branch offset field of the current instruction.
- IMM26  in  26  jump target field of the current instruction.
- JRTarget  in  32  register value for jr.
- step  in  1  core retires the current instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  byte address of the fetch, equals PC.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched word, valid when imem_ack=1.
- instr  out  32  instruction register.
- instr_valid  out  1  instr holds the instruction at PC, ready for execution.
- PC  out  32  current PC.
- PCPLUS4  out  32  PC+4, for jal-style writeback.

## Operation

- States: IDLE, FETCH, EXEC.
- IDLE: outputs quiet; next edge goes to FETCH.
- FETCH: imem_req=1, imem_addr=PC. On edge with imem_ack=1: instr<=imem_rdata, go EXEC. Otherwise hold. step ignored.
- EXEC: instr_valid=1, imem_req=0. On edge with step=1: PC<=NPC, go FETCH. Otherwise hold. imem_ack ignored.
- NPC (combinational, 32-bit, wraps modulo 2^32):
  - PLUS4: PC+4.
  - BRANCH: PC+4 + (sign_extend(IMM16) << 2).
  - JUMP: {PCPLUS4[31:28], IMM26, 2'b00}.
  - 11: per Configuration.
- PC[1:0] always 0; no misalignment possible.
- NPCOp, IMM16, IMM26, JRTarget sampled only on the step edge in EXEC.

## Timing

- Reset values: PC=RESET_PC, instr=32'h0000_0000, instr_valid=0, imem_req=0, imem_addr=RESET_PC, PCPLUS4=RESET_PC+4, state IDLE.
- Reset asserted mid-FETCH or mid-EXEC: request and instruction dropped immediately; memory must tolerate an abandoned req.
- First request in cycle 1 after reset release (IDLE occupies cycle 0).
- Zero-wait memory (ack in same cycle as req): instr_valid rises the next cycle; minimum 2 cycles per instruction.
- N wait cycles add N cycles; req and imem_addr stable until ack.
- instr_valid falls the cycle after step; new PC visible on PC/imem_addr in that same cycle.

## Configuration

- NPC_JR_EN defined: NPCOp=11 gives NPC={JRTarget[31:2],2'b00}.
- NPC_JR_EN undefined: NPCOp=11 treated as PLUS4; JRTarget ignored.

## Test plan

- Reset, then zero-wait memory returning 32'h2008_0005: imem_addr=32'h3000 in cycle 1, instr=32'h2008_0005 with instr_valid=1 in cycle 2.
- Three steps with NPCOp=00, 3-cycle ack latency: fetch addresses 0x3000, 0x3004, 0x3008; each stalls req exactly 3 cycles with stable address.
- At PC=0x3010, NPCOp=01, IMM16=16'hFFFC: next fetch at 0x3004; with IMM16=16'h0003: 0x3020.
- At PC=0x3010, NPCOp=10, IMM26=26'h0000C08: next fetch at 0x0000_3020.
- NPCOp=11, JRTarget=32'h0000_4007: with NPC_JR_EN next fetch 0x4004; without, 0x3014 (PC+4).
- rst pulsed while imem_req=1 awaiting ack: req drops immediately, PC returns to 0x3000, refetch 0x3000 one cycle after release; step held high during FETCH has no effect.
